// File: rtl/ring_arb_pkg.sv
// ring_arb_pkg: shared state encoding and token helpers for the ring round-robin arbiter.
package ring_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;
  function automatic logic [15:0] rotl1(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (i < n) r[(i + 1) % n] = v[i];
    return r;
  endfunction
  function automatic logic [3:0] oh2bin(input logic [15:0] v);
    logic [3:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) if (v[i]) b = b | 4'(i);
    return b;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: circular priority picker; first set req bit at or above the token, wrapping to bit 0.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] token,
  input  logic [N-1:0] req,
  output logic [N-1:0] winner,
  output logic         any
);
  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_d;
  logic [2*N-1:0] w_f;
  // Lower copy keeps only bits at/above the token; upper copy supplies the wrap-around.
  assign w_mask = ~(token - N'(1));
  assign w_d    = {req, req & w_mask};
  assign w_f    = w_d & (~w_d + (2*N)'(1));
  assign winner = w_f[N-1:0] | w_f[2*N-1:N];
  assign any    = |req;
endmodule

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: round-robin arbiter with rotating one-hot token, bounded bursts and a one-cycle turnaround.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic [N-1:0]         token,
  output logic                 timeout
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);
  state_t        r_state;
  logic [N-1:0]  r_gnt;
  logic [N-1:0]  r_token;
  logic [CW-1:0] r_cnt;
  logic          r_valid;
  logic [IW-1:0] r_id;
  logic          r_timeout;
  logic [N-1:0]  w_win;
  logic          w_any;
  logic          w_own;
  rr_pick #(.N(N)) u_pick (.token(r_token), .req(req), .winner(w_win), .any(w_any));
  assign w_own = |(req & r_gnt);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_token   <= N'(1);
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        IDLE, RELEASE: begin
          r_state <= (en && w_any) ? GRANT : IDLE;
          r_gnt   <= (en && w_any) ? w_win : '0;
          r_valid <= en && w_any;
          r_id    <= (en && w_any) ? IW'(oh2bin(16'(w_win))) : '0;
          if (en && w_any) r_cnt <= CW'(1);
        end
        GRANT: begin
          if (!w_own || r_cnt == CW'(MAX_HOLD)) begin
            r_state   <= RELEASE;
            r_gnt     <= '0;
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_token   <= N'(rotl1(16'(r_gnt), N));
            r_timeout <= w_own;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign gnt       = r_gnt;
  assign gnt_valid = r_valid;
  assign gnt_id    = r_id;
  assign token     = r_token;
  assign timeout   = r_timeout;
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb_ring_rr_arbiter: directed scoreboard bench for ring_rr_arbiter with N=4, MAX_HOLD=4.
module tb_ring_rr_arbiter;
  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] token;
    logic       to;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [3:0] token;
  logic       timeout;
  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         step_n = 0;
  ring_rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .gnt(gnt), .gnt_valid(gnt_valid),
    .gnt_id(gnt_id), .token(token), .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic logic [1:0] idx(input logic [3:0] g);
    logic [1:0] b;
    b = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) b = 2'(i);
    return b;
  endfunction
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s step=%0d got=%b exp=%b", tag, step_n, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic [3:0] rq,
                      input logic [3:0] eg, input logic [3:0] et, input logic eto);
    exp_t x;
    rst = r;
    en  = e;
    req = rq;
    sb.push_back('{gnt: eg, token: et, to: eto});
    @(posedge clk);
    #1;
    step_n++;
    x = sb.pop_front();
    chk("gnt", gnt, x.gnt);
    chk("gnt_valid", {3'b0, gnt_valid}, {3'b0, |x.gnt});
    chk("gnt_id", {2'b0, gnt_id}, {2'b0, idx(x.gnt)});
    chk("token", token, x.token);
    chk("timeout", {3'b0, timeout}, {3'b0, x.to});
    chk("token_onehot", {3'b0, $onehot(token)}, 4'd1);
    chk("gnt_onehot0", {3'b0, $onehot0(gnt)}, 4'd1);
  endtask
  initial begin
    // reset held two cycles with all requesting
    step(1, 1, 4'b1111, 4'b0000, 4'b0001, 0);
    step(1, 1, 4'b1111, 4'b0000, 4'b0001, 0);
    step(0, 1, 4'b1111, 4'b0001, 4'b0001, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0010, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0010, 0);
    // single short request
    step(0, 1, 4'b0100, 4'b0100, 4'b0010, 0);
    step(0, 1, 4'b0100, 4'b0100, 4'b0010, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b1000, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b1000, 0);
    // wrap-around from token bit 3
    step(0, 1, 4'b0011, 4'b0001, 4'b1000, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0010, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0010, 0);
    // forced rotation with req=0110 held
    repeat (4) step(0, 1, 4'b0110, 4'b0010, 4'b0010, 0);
    step(0, 1, 4'b0110, 4'b0000, 4'b0100, 1);
    repeat (4) step(0, 1, 4'b0110, 4'b0100, 4'b0100, 0);
    step(0, 1, 4'b0110, 4'b0000, 4'b1000, 1);
    step(0, 1, 4'b0110, 4'b0010, 4'b1000, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0100, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0100, 0);
    // owner drops exactly when the counter reaches MAX_HOLD: no timeout
    repeat (4) step(0, 1, 4'b1000, 4'b1000, 4'b0100, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0001, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0001, 0);
    // en gating during a burst
    step(0, 1, 4'b0011, 4'b0001, 4'b0001, 0);
    repeat (3) step(0, 0, 4'b0011, 4'b0001, 4'b0001, 0);
    step(0, 0, 4'b0011, 4'b0000, 4'b0010, 1);
    step(0, 0, 4'b0011, 4'b0000, 4'b0010, 0);
    step(0, 0, 4'b0011, 4'b0000, 4'b0010, 0);
    step(0, 1, 4'b0011, 4'b0010, 4'b0010, 0);
    step(0, 1, 4'b0010, 4'b0010, 4'b0010, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0100, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0100, 0);
    // reset on cycle 2 of a grant to 0100
    step(0, 1, 4'b0110, 4'b0100, 4'b0100, 0);
    step(1, 1, 4'b0110, 4'b0000, 4'b0001, 0);
    step(0, 1, 4'b0110, 4'b0010, 4'b0001, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0100, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0100, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ring_rr_arbiter.md
# ring_rr_arbiter

Round-robin arbiter that shares one downstream resource among N requesters by rotating a one-hot priority token, the same structure as our ring counters. It sits between requesters and the shared resource. It issues a registered one-hot grant, holds the grant while the owner keeps requesting, and force-releases after a bounded burst. After every release the token advances past the last owner, so every requester is served within bounded latency.

## Interface
- N, 4: number of requesters; legal range 2..16.
- MAX_HOLD, 8: maximum consecutive grant cycles per owner; legal range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  arbitration enable; gates new grants only.
- req  in  N  request vector; req[i] is held high by requester i while it wants or uses the resource.
- gnt  out  N  registered one-hot grant, or all zero.
- gnt_valid  out  1  high when gnt is nonzero.
- gnt_id  out  $clog2(N)  binary index of the grant owner; 0 when gnt_valid is low.
- token  out  N  one-hot priority pointer, exposed for debug and coverage.
- timeout  out  1  one-cycle pulse on a forced release.

## Operation
- State machine with three states: IDLE, GRANT, RELEASE.
- Reset values: state IDLE, token = 1 (bit 0), gnt = 0, gnt_valid = 0, gnt_id = 0, timeout = 0, hold counter = 0.
- Winner selection (combinational): the first i with req[i]=1, scanning circularly from the token bit upward and wrapping from N-1 to 0.
- IDLE:
  - If en=1 and req≠0: next state GRANT; gnt = onehot(winner); hold counter = 1.
  - Otherwise: stay in IDLE.
- GRANT:
  - If req[owner]=0: next state RELEASE.
  - Else if hold counter = MAX_HOLD: next state RELEASE and timeout=1 for the next cycle.
  - Else: hold counter increments.
  - Requests from non-owners are ignored while in GRANT.
- On every GRANT→RELEASE transition, token = gnt rotated left by 1 (bit N-1 wraps to bit 0).
- RELEASE:
  - gnt = 0 for exactly one turnaround cycle.
  - Arbitration is evaluated here using the updated token. If en=1 and req≠0, the next state is GRANT; otherwise the next state is IDLE.
- en=0 while in GRANT: the current burst runs to normal completion; no new grant follows until en=1.
- Token is never all-zero and never multi-hot. Bench asserts: onehot(token); onehot0(gnt); gnt_valid == |gnt.
- Hold counter width is $clog2(MAX_HOLD+1); it never wraps.

## Timing
- Request latency: req sampled in an IDLE or RELEASE cycle t gives gnt at cycle t+1.
- Minimum grant length is 1 cycle.
- Release latency: owner drops req in cycle t, gnt falls at t+1, and the next grant can appear at t+2.
- Maximum grant length is exactly MAX_HOLD cycles. timeout is high in the RELEASE cycle that follows the last grant cycle.
- Gap between consecutive grants is exactly one cycle, even when the same requester wins again.
- Worst-case wait for a continuously requesting port is (N-1)·(MAX_HOLD+1)+1 cycles.
- Simultaneous req rise on several ports: the token order decides the winner.
- Owner drops req in the same cycle the counter hits MAX_HOLD: treated as a normal release with timeout=0.
- rst asserted mid-burst: at the next edge every output returns to its reset value and token = 1. Requests seen in the rst cycle are discarded.

## Structure
- Shared package ring_arb_pkg contains:
  - the state typedef (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2);
  - the rotate-left-by-one function;
  - the one-hot-to-binary function used for gnt_id.
- One sub-module, rr_pick: combinational circular priority picker. Inputs are token[N] and req[N]; outputs are onehot winner[N] and any. It is implemented with the double-width mask-and-find-first technique.
- The top level contains the FSM, the hold counter, the token register and the output registers. All outputs are driven directly from registers.

## Test plan
All scenarios use N=4, MAX_HOLD=4.
- Reset: hold rst high 2 cycles with req=1111 → gnt=0000, token=0001, timeout=0 throughout; first grant after rst falls is 0001.
- Single short request: req=0100 for 2 cycles starting at cycle t → gnt=0100 at cycles t+1 and t+2, gnt=0 at t+3, token=1000 afterwards.
- Forced rotation: req=0110 held constantly → gnt=0010 for 4 cycles, timeout pulse with 1-cycle gap, gnt=0100 for 4 cycles, gap, gnt=0010 again.
- Wrap-around: token=1000 and req=0011 → winner 0001; after release token=0010.
- en gating: en=0 during a burst of 0001 with req=0011 → the burst completes, no further grant; en=1 gives gnt=0010 one cycle later.
- Mid-burst reset: rst pulsed on cycle 2 of a grant to 0100 → gnt=0000 and token=0001 on the next cycle, then a fresh grant to the lowest requesting port at or after bit 0.
